// File: rtl/ram_sp_bank.sv
// ram_sp_bank: parametrised single-port synchronous RAM with per-byte write
// enables, optional output register, optional write-through and a clear
// engine that zeroes the whole array after reset or on a clr pulse.
module ram_sp_bank #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned WR_THRU    = 0,
  parameter int unsigned CLR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] be,
  input  logic                clr,
  output logic                ready,
  output logic [DATA_W-1:0]   q,
  output logic                q_valid,
  output logic                busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                accept;
  logic                rd_fire;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   merged;
  logic [DATA_W-1:0]   rd_word;

  // Next-state, handshake and request qualification; clr beats a same-cycle req
  always_comb begin
    state_nx = state;
    ready    = (state == S_IDLE);
    busy     = (state == S_CLEAR);
    accept   = req && (state == S_IDLE) && !clr;
    case (state)
      S_IDLE:  if (clr) state_nx = S_CLEAR;
      S_CLEAR: if (cnt == '1) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Byte-merged word for writes; also the value returned on write-through
  always_comb begin
    old_word = mem[addr];
    merged   = old_word;
    for (int unsigned b = 0; b < NB; b++) begin
      if (be[b]) merged[8*b +: 8] = data[8*b +: 8];
    end
    rd_word = we ? merged : old_word;
    rd_fire = accept && (!we || (WR_THRU != 0));
  end

  // FSM state register and clear address counter (wraps to 0 as CLEAR ends)
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_CLEAR) cnt <= cnt + 1'b1;
    end
  end

  // Array write port: clear engine owns the port while CLEAR is active
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) mem[cnt] <= '0;
      else if (accept && we) mem[addr] <= merged;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              s1_valid;
      logic [DATA_W-1:0] s1_data;
      // Two-stage read pipeline; stage 2 keeps draining through a clear
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid <= 1'b0;
          s1_data  <= '0;
          q_valid  <= 1'b0;
          q        <= '0;
        end else begin
          s1_valid <= rd_fire;
          if (rd_fire) s1_data <= rd_word;
          q_valid <= s1_valid;
          if (s1_valid) q <= s1_data;
        end
      end
    end else begin : g_nreg
      // Single-stage read; q holds its value between valid pulses
      always_ff @(posedge clk) begin
        if (rst) begin
          q_valid <= 1'b0;
          q       <= '0;
        end else begin
          q_valid <= rd_fire;
          if (rd_fire) q <= rd_word;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ram_sp_bank.sv
// tb_ram_sp_bank: directed self-checking bench for ram_sp_bank, three
// instances covering the default build, a 32-bit registered-output build
// and a write-through build.
module tb_ram_sp_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // A: defaults (8-bit, clear on reset, no output reg, no write-through)
  logic       a_rst, a_req, a_we, a_clr, a_ready, a_q_valid, a_busy;
  logic [5:0] a_addr;
  logic [7:0] a_data, a_q;
  logic [0:0] a_be;

  // B: 32-bit, output register, no clear on reset
  logic        b_rst, b_req, b_we, b_clr, b_ready, b_q_valid, b_busy;
  logic [5:0]  b_addr;
  logic [31:0] b_data, b_q;
  logic [3:0]  b_be;

  // C: 8-bit write-through, no clear on reset
  logic       c_rst, c_req, c_we, c_clr, c_ready, c_q_valid, c_busy;
  logic [5:0] c_addr;
  logic [7:0] c_data, c_q;
  logic [0:0] c_be;

  ram_sp_bank u_a (
    .clk(clk), .rst(a_rst), .req(a_req), .we(a_we), .addr(a_addr),
    .data(a_data), .be(a_be), .clr(a_clr), .ready(a_ready), .q(a_q),
    .q_valid(a_q_valid), .busy(a_busy)
  );

  ram_sp_bank #(.DATA_W(32), .ADDR_W(6), .OUT_REG(1), .WR_THRU(0), .CLR_ON_RST(0)) u_b (
    .clk(clk), .rst(b_rst), .req(b_req), .we(b_we), .addr(b_addr),
    .data(b_data), .be(b_be), .clr(b_clr), .ready(b_ready), .q(b_q),
    .q_valid(b_q_valid), .busy(b_busy)
  );

  ram_sp_bank #(.DATA_W(8), .ADDR_W(6), .OUT_REG(0), .WR_THRU(1), .CLR_ON_RST(0)) u_c (
    .clk(clk), .rst(c_rst), .req(c_req), .we(c_we), .addr(c_addr),
    .data(c_data), .be(c_be), .clr(c_clr), .ready(c_ready), .q(c_q),
    .q_valid(c_q_valid), .busy(c_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with a_busy high (bounded), noting any q_valid seen
  task automatic a_busy_len(output int n, output logic seen_qv);
    n = 0;
    seen_qv = 1'b0;
    while (a_busy && n < 200) begin
      if (a_ready) seen_qv = 1'b1;
      n++;
      step();
      if (a_q_valid) seen_qv = 1'b1;
    end
  endtask

  int   len;
  logic seen;
  logic [5:0] chk_addrs [4];

  initial begin
    a_rst = 1; a_req = 0; a_we = 0; a_clr = 0; a_addr = '0; a_data = '0; a_be = '1;
    b_rst = 1; b_req = 0; b_we = 0; b_clr = 0; b_addr = '0; b_data = '0; b_be = '1;
    c_rst = 1; c_req = 0; c_we = 0; c_clr = 0; c_addr = '0; c_data = '0; c_be = '1;
    step();
    a_rst = 0; b_rst = 0; c_rst = 0;

    // Reset state
    check("a_rst_q", a_q, 0);
    check("a_rst_qv", a_q_valid, 0);
    check("a_rst_busy", a_busy, 1);
    check("a_rst_ready", a_ready, 0);
    check("b_rst_busy", b_busy, 0);
    check("b_rst_ready", b_ready, 1);
    check("b_rst_qv", b_q_valid, 0);
    check("c_rst_ready", c_ready, 1);

    // Automatic clear after reset, reads held during it are ignored
    a_req = 1; a_we = 0; a_addr = 6'd3;
    a_busy_len(len, seen);
    check("a_clr_len", len, 64);
    check("a_clr_noqv", seen, 0);
    check("a_clr_ready", a_ready, 1);

    // Back-to-back reads of every address return 0 one cycle later
    for (int i = 0; i < 64; i++) begin
      a_addr = 6'(i);
      step();
      check("a_rd0_qv", a_q_valid, 1);
      check("a_rd0_q", a_q, 0);
    end
    a_req = 0;
    step();
    check("a_idle_qv", a_q_valid, 0);

    // Fill array, then 0xFF to addr 3 with an immediate read-after-write
    a_req = 1; a_we = 1; a_be = 1'b1;
    for (int i = 0; i < 64; i++) begin
      a_addr = 6'(i);
      a_data = 8'(i) ^ 8'hC3;
      step();
      check("a_wr_noqv", a_q_valid, 0);
    end
    a_addr = 6'd3; a_data = 8'hFF;
    step();
    a_we = 0;
    step();
    check("a_raw_qv", a_q_valid, 1);
    check("a_raw_q", a_q, 8'hFF);
    a_addr = 6'd10;
    step();
    check("a_rd10", a_q, 8'hC9);
    // be=0 write is a no-op
    a_we = 1; a_be = 1'b0; a_data = 8'h00;
    step();
    a_we = 0; a_be = 1'b1;
    step();
    check("a_be0_q", a_q, 8'hC9);
    a_req = 0;
    step();
    check("a_hold_qv", a_q_valid, 0);
    check("a_hold_q", a_q, 8'hC9);

    // clr with same-cycle read: read dropped, full clear follows
    a_clr = 1; a_req = 1; a_we = 0; a_addr = 6'd3;
    step();
    a_clr = 0; a_req = 0;
    check("a_clrrd_qv", a_q_valid, 0);
    check("a_clrrd_q", a_q, 8'hC9);
    check("a_clrcmd_busy", a_busy, 1);
    a_clr = 1;
    step();
    a_clr = 0;
    a_busy_len(len, seen);
    check("a_clrcmd_len", len, 63);
    chk_addrs[0] = 6'd3; chk_addrs[1] = 6'd10; chk_addrs[2] = 6'd0; chk_addrs[3] = 6'd63;
    a_req = 1;
    for (int i = 0; i < 4; i++) begin
      a_addr = chk_addrs[i];
      step();
      check("a_postclr_qv", a_q_valid, 1);
      check("a_postclr_q", a_q, 0);
    end
    a_req = 0;

    // Reset at clear cycle 20 restarts a full clear; writes during it dropped
    a_clr = 1;
    step();
    a_clr = 0;
    repeat (19) step();
    check("a_mid_busy", a_busy, 1);
    a_rst = 1;
    step();
    a_rst = 0;
    a_req = 1; a_we = 1; a_addr = 6'd0; a_data = 8'h77;
    a_busy_len(len, seen);
    check("a_abort_len", len, 64);
    check("a_abort_noqv", seen, 0);
    a_we = 0;
    step();
    check("a_abort_rd_qv", a_q_valid, 1);
    check("a_abort_rd_q", a_q, 0);
    a_req = 0;

    // B: byte-enable merge, 32-bit, two-cycle latency
    b_req = 1; b_we = 1; b_addr = 6'd5; b_data = 32'hAABBCCDD; b_be = 4'b1111;
    step();
    check("b_wr_noqv", b_q_valid, 0);
    b_data = 32'h11223344; b_be = 4'b0101;
    step();
    b_we = 0;
    step();
    check("b_rd5_lat1", b_q_valid, 0);
    b_req = 0;
    step();
    check("b_rd5_qv", b_q_valid, 1);
    check("b_rd5_q", b_q, 32'hAA22CC44);
    b_req = 1; b_we = 1; b_be = 4'b1111;
    for (int i = 1; i <= 3; i++) begin
      b_addr = 6'(i);
      b_data = 32'(i * 16);
      step();
    end
    check("b_wr_q_held", b_q, 32'hAA22CC44);
    b_we = 0;
    b_addr = 6'd1;
    step();
    check("b_pipe_lat", b_q_valid, 0);
    for (int i = 2; i <= 4; i++) begin
      if (i <= 3) b_addr = 6'(i);
      else b_req = 0;
      step();
      check("b_pipe_qv", b_q_valid, 1);
      check("b_pipe_q", b_q, 32'((i - 1) * 16));
    end
    step();
    check("b_pipe_end", b_q_valid, 0);
    check("b_pipe_hold", b_q, 32'h30);

    // C: write-through returns merged word next cycle
    c_req = 1; c_we = 1; c_addr = 6'd9; c_data = 8'h5A; c_be = 1'b1;
    step();
    check("c_wt_qv", c_q_valid, 1);
    check("c_wt_q", c_q, 8'h5A);
    c_data = 8'h00; c_be = 1'b0;
    step();
    check("c_wt_be0_qv", c_q_valid, 1);
    check("c_wt_be0_q", c_q, 8'h5A);
    c_req = 0;
    step();
    check("c_idle_qv", c_q_valid, 0);
    check("c_idle_q", c_q, 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
